// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for the EX stage.
// result_o = {remainder, quotient}; handles DIV/DIVU, divide-by-zero and flush.
module div #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } state_t;

   localparam logic [DATA_W-1:0]   ONE_D  = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0]   ZERO_D = {DATA_W{1'b0}};
   localparam logic [CNT_W-1:0]    ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]    ZERO_C = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]    LAST_C = CNT_W'(DATA_W);
   localparam logic [2*DATA_W-1:0] ZERO_R = {(2*DATA_W){1'b0}};

   function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] v);
      return ~v + ONE_D;
   endfunction

   state_t                state_r, state_s;
   logic [CNT_W-1:0]      cnt_r, cnt_s;
   logic [DATA_W-1:0]     rem_r, rem_s;
   logic [DATA_W-1:0]     dvd_r, dvd_s;     // dividend shifts out, quotient shifts in
   logic [DATA_W-1:0]     dsr_r, dsr_s;
   logic                  signed_r, signed_s;
   logic                  sign1_r, sign1_s;
   logic                  sign2_r, sign2_s;
   logic [2*DATA_W-1:0]   result_r, result_s;
   logic                  ready_r, ready_s;
   logic [DATA_W:0]       part_s, trial_s;
   logic [DATA_W-1:0]     quot_s, remd_s;

   // Next-state, datapath step and output computation.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      rem_s    = rem_r;
      dvd_s    = dvd_r;
      dsr_s    = dsr_r;
      signed_s = signed_r;
      sign1_s  = sign1_r;
      sign2_s  = sign2_r;
      result_s = result_r;
      ready_s  = ready_r;
      part_s   = {rem_r, dvd_r[DATA_W-1]};
      trial_s  = part_s - {1'b0, dsr_r};
      quot_s   = (signed_r && (sign1_r ^ sign2_r)) ? neg(dvd_r) : dvd_r;
      remd_s   = (signed_r && sign1_r) ? neg(rem_r) : rem_r;
      case (state_r)
         DIV_FREE: begin
            result_s = ZERO_R;
            ready_s  = 1'b0;
            if (start_i && !annul_i) begin
               if (opdata2_i == ZERO_D) begin
                  state_s = DIV_BY_ZERO;
               end else begin
                  state_s  = DIV_ON;
                  signed_s = signed_div_i;
                  sign1_s  = opdata1_i[DATA_W-1];
                  sign2_s  = opdata2_i[DATA_W-1];
                  dvd_s    = (signed_div_i && opdata1_i[DATA_W-1]) ? neg(opdata1_i) : opdata1_i;
                  dsr_s    = (signed_div_i && opdata2_i[DATA_W-1]) ? neg(opdata2_i) : opdata2_i;
                  cnt_s    = ZERO_C;
                  rem_s    = ZERO_D;
               end
            end else begin
               state_s = DIV_FREE;
            end
         end
         DIV_BY_ZERO: begin
            state_s  = DIV_END;
            result_s = ZERO_R;
            ready_s  = 1'b1;
         end
         DIV_ON: begin
            if (annul_i) begin
               state_s  = DIV_FREE;
               result_s = ZERO_R;
               ready_s  = 1'b0;
            end else if (cnt_r == LAST_C) begin
               state_s  = DIV_END;
               result_s = {remd_s, quot_s};
               ready_s  = 1'b1;
            end else begin
               cnt_s = cnt_r + ONE_C;
               // Restoring step: keep the shifted remainder when the trial goes negative.
               if (!trial_s[DATA_W]) begin
                  rem_s = trial_s[DATA_W-1:0];
                  dvd_s = {dvd_r[DATA_W-2:0], 1'b1};
               end else begin
                  rem_s = part_s[DATA_W-1:0];
                  dvd_s = {dvd_r[DATA_W-2:0], 1'b0};
               end
            end
         end
         DIV_END: begin
            if (!start_i) begin
               state_s  = DIV_FREE;
               result_s = ZERO_R;
               ready_s  = 1'b0;
            end else begin
               state_s = DIV_END;
            end
         end
         default: begin
            state_s  = DIV_FREE;
            result_s = ZERO_R;
            ready_s  = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= DIV_FREE;
         cnt_r    <= ZERO_C;
         rem_r    <= ZERO_D;
         dvd_r    <= ZERO_D;
         dsr_r    <= ZERO_D;
         signed_r <= 1'b0;
         sign1_r  <= 1'b0;
         sign2_r  <= 1'b0;
         result_r <= ZERO_R;
         ready_r  <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         rem_r    <= rem_s;
         dvd_r    <= dvd_s;
         dsr_r    <= dsr_s;
         signed_r <= signed_s;
         sign1_r  <= sign1_s;
         sign2_r  <= sign2_s;
         result_r <= result_s;
         ready_r  <= ready_s;
      end
   end

   assign result_o = result_r;
   assign ready_o  = ready_r;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the radix-2 divider.
module tb_div;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int vec_cnt = 0;
   int err_cnt = 0;

   div #(.DATA_W(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present a request, let E0 sample it, then scramble the operands.
   task automatic launch(input logic sd, input logic [31:0] a, input logic [31:0] b);
      signed_div_i = sd;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      @(negedge clk);
      signed_div_i = ~sd;
      opdata1_i    = ~a;
      opdata2_i    = 32'h0000_0000;
   endtask

   // n = 1 + index of the edge after E0 at which ready_o is first seen.
   task automatic wait_ready(output int n);
      n = 1;
      while (!ready_o && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic release_start();
      start_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
      opdata1_i = 32'h0; opdata2_i = 32'h0;
      #1;
      vec_cnt++;
      if (ready_o !== 1'b0) begin err_cnt++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
      vec_cnt++;
      if (result_o !== 64'h0) begin err_cnt++; $display("FAIL reset_result: got %h expected 0", result_o); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unsigned();
      int n;
      launch(1'b0, 32'd100, 32'd7);
      wait_ready(n);
      vec_cnt++;
      if (n !== 34) begin err_cnt++; $display("FAIL udiv_latency: got %0d expected 34", n); end
      vec_cnt++;
      if (result_o !== {32'h0000_0002, 32'h0000_000E}) begin
         err_cnt++; $display("FAIL udiv_result: got %h expected %h", result_o, {32'h0000_0002, 32'h0000_000E});
      end
      repeat (3) @(negedge clk);
      vec_cnt++;
      if (ready_o !== 1'b1 || result_o !== {32'h0000_0002, 32'h0000_000E}) begin
         err_cnt++; $display("FAIL udiv_hold: got ready=%b result=%h expected ready=1 result=%h", ready_o, result_o, {32'h0000_0002, 32'h0000_000E});
      end
      release_start();
      vec_cnt++;
      if (ready_o !== 1'b0) begin err_cnt++; $display("FAIL udiv_release_ready: got %b expected 0", ready_o); end
      vec_cnt++;
      if (result_o !== 64'h0) begin err_cnt++; $display("FAIL udiv_release_result: got %h expected 0", result_o); end
   endtask

   task automatic test_signed();
      int n;
      launch(1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_ready(n);
      vec_cnt++;
      if (n !== 34 || result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
         err_cnt++; $display("FAIL sdiv_m7_2: got n=%0d result=%h expected n=34 result=%h", n, result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      end
      release_start();
      launch(1'b1, 32'd7, 32'hFFFF_FFFE);
      wait_ready(n);
      vec_cnt++;
      if (result_o !== {32'h0000_0001, 32'hFFFF_FFFD}) begin
         err_cnt++; $display("FAIL sdiv_7_m2: got %h expected %h", result_o, {32'h0000_0001, 32'hFFFF_FFFD});
      end
      release_start();
      launch(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
      wait_ready(n);
      vec_cnt++;
      if (result_o !== {32'hFFFF_FFFF, 32'h0000_0003}) begin
         err_cnt++; $display("FAIL sdiv_m7_m2: got %h expected %h", result_o, {32'hFFFF_FFFF, 32'h0000_0003});
      end
      release_start();
   endtask

   task automatic test_overflow();
      int n;
      launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_ready(n);
      vec_cnt++;
      if (result_o !== {32'h0000_0000, 32'h8000_0000}) begin
         err_cnt++; $display("FAIL sdiv_overflow: got %h expected %h", result_o, {32'h0000_0000, 32'h8000_0000});
      end
      release_start();
      launch(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_ready(n);
      vec_cnt++;
      if (result_o !== {32'h8000_0000, 32'h0000_0000}) begin
         err_cnt++; $display("FAIL udiv_large: got %h expected %h", result_o, {32'h8000_0000, 32'h0000_0000});
      end
      release_start();
      launch(1'b1, 32'h0000_0000, 32'd5);
      wait_ready(n);
      vec_cnt++;
      if (n !== 34 || result_o !== 64'h0) begin
         err_cnt++; $display("FAIL zero_dividend: got n=%0d result=%h expected n=34 result=0", n, result_o);
      end
      release_start();
   endtask

   task automatic test_div_zero();
      int n;
      launch(1'b0, 32'd5, 32'd0);
      wait_ready(n);
      vec_cnt++;
      if (n !== 2) begin err_cnt++; $display("FAIL dbz_latency: got %0d expected 2", n); end
      vec_cnt++;
      if (result_o !== 64'h0) begin err_cnt++; $display("FAIL dbz_result: got %h expected 0", result_o); end
      release_start();
   endtask

   task automatic test_annul();
      int n;
      logic seen;
      launch(1'b0, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      annul_i = 1'b1;
      @(negedge clk);
      annul_i = 1'b0;
      start_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ready_o) seen = 1'b1;
         @(negedge clk);
      end
      vec_cnt++;
      if (seen !== 1'b0) begin err_cnt++; $display("FAIL annul_no_ready: got %b expected 0", seen); end
      start_i = 1'b1;
      annul_i = 1'b1;
      opdata1_i = 32'd50; opdata2_i = 32'd5; signed_div_i = 1'b0;
      @(negedge clk);
      start_i = 1'b0;
      annul_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ready_o) seen = 1'b1;
         @(negedge clk);
      end
      vec_cnt++;
      if (seen !== 1'b0) begin err_cnt++; $display("FAIL annul_blocks_start: got %b expected 0", seen); end
      launch(1'b0, 32'd9, 32'd3);
      wait_ready(n);
      vec_cnt++;
      if (n !== 34 || result_o !== {32'h0, 32'h3}) begin
         err_cnt++; $display("FAIL annul_restart: got n=%0d result=%h expected n=34 result=%h", n, result_o, {32'h0, 32'h3});
      end
      release_start();
   endtask

   task automatic test_async_reset();
      int n;
      launch(1'b0, 32'd1000, 32'd3);
      repeat (19) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      vec_cnt++;
      if (ready_o !== 1'b0 || result_o !== 64'h0) begin
         err_cnt++; $display("FAIL rst_midop: got ready=%b result=%h expected 0/0", ready_o, result_o);
      end
      @(negedge clk);
      rst = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      launch(1'b0, 32'd1000, 32'd3);
      wait_ready(n);
      vec_cnt++;
      if (n !== 34 || result_o !== {32'h0000_0001, 32'h0000_014D}) begin
         err_cnt++; $display("FAIL rst_restart: got n=%0d result=%h expected n=34 result=%h", n, result_o, {32'h0000_0001, 32'h0000_014D});
      end
      #2 rst = 1'b0;
      #1;
      vec_cnt++;
      if (ready_o !== 1'b0 || result_o !== 64'h0) begin
         err_cnt++; $display("FAIL rst_in_end: got ready=%b result=%h expected 0/0", ready_o, result_o);
      end
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_overflow();
      test_div_zero();
      test_annul();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
